// File: rtl/pattern_pkg.sv
// pattern_pkg: shared definitions for the pattern checker.
// Holds direction codes, FSM state encoding, the pattern length and
// the 4x4 pattern ROM that maps the latched `random` select onto
// the four expected directions.
package pattern_pkg;

  // Direction codes as seen on press_dir
  typedef enum logic [1:0] {
    DIR_L = 2'd0,
    DIR_U = 2'd1,
    DIR_R = 2'd2,
    DIR_D = 2'd3
  } dir_e;

  // Checker FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENTRY  = 3'd1,
    SUBMIT = 3'd2,
    PASS   = 3'd3,
    FAIL   = 3'd4
  } state_e;

  localparam int SEQ_LEN = 4;

  // PATTERN_ROM[select][step]
  localparam logic [1:0] PATTERN_ROM [4][4] = '{
    '{DIR_L, DIR_U, DIR_D, DIR_D},
    '{DIR_R, DIR_R, DIR_U, DIR_L},
    '{DIR_D, DIR_L, DIR_U, DIR_R},
    '{DIR_U, DIR_D, DIR_L, DIR_R}
  };

endpackage

// File: rtl/pattern_checker_if.sv
// pattern_checker_if: gameplay-side handshake of the pattern checker.
//   start       gameplay -> checker  one-clk pulse arming a check
//   random      gameplay -> checker  pattern select, latched on start
//   busy        checker -> gameplay  high while a check is armed
//   step        checker -> gameplay  correct directions entered so far
//   press_valid checker -> gameplay  one-clk pulse per direction press
//   press_dir   checker -> gameplay  direction of the last press
//   pass/fail   checker -> gameplay  one-clk verdict pulses
//   timeout     checker -> gameplay  (PATTERN_TIMEOUT_EN only) pulses with fail
// Modport master is the gameplay side, slave is the checker.
interface pattern_checker_if;
  logic       start;
  logic [1:0] random;
  logic       busy;
  logic [2:0] step;
  logic       press_valid;
  logic [1:0] press_dir;
  logic       pass;
  logic       fail;
`ifdef PATTERN_TIMEOUT_EN
  logic       timeout;
`endif

  modport master (
    output start, random,
    input  busy, step, press_valid, press_dir, pass, fail
`ifdef PATTERN_TIMEOUT_EN
    , input timeout
`endif
  );

  modport slave (
    input  start, random,
    output busy, step, press_valid, press_dir, pass, fail
`ifdef PATTERN_TIMEOUT_EN
    , output timeout
`endif
  );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: one raw button to a clean one-clk press pulse.
//   clk, rst    system clock, synchronous active-high reset
//   sample_en   debounce sample strobe
//   btn_raw     asynchronous raw button level
//   press       one-clk pulse when the accepted level rises
// The raw level passes a 2-FF synchronizer; the accepted level only
// flips after DEBOUNCE_TICKS consecutive samples disagreeing with it.
// Releases are accepted silently.
module btn_debounce #(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronizer, stability counter and rising-edge pulse. A sample that
  // agrees with the accepted level restarts the count, so isolated
  // glitches never accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sample_en) begin
        if (sync2 == level) begin
          cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
          cnt   <= '0;
          level <= sync2;
          press <= sync2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pattern_checker.sv
// pattern_checker: debounces the five Basys buttons and scores the
// player's entry against the 4-step pattern selected by `random`.
//   clk, rst                    system clock, synchronous active-high reset
//   sample_en                   debounce sample strobe (500 Hz)
//   btnL/btnU/btnR/btnD/btnM    raw buttons
//   bus (pattern_checker_if.slave) start/random in; busy, step,
//                               press_valid, press_dir, pass, fail out
// Optional macro PATTERN_TIMEOUT_EN adds an idle timer (TIMEOUT_TICKS
// sample ticks) that forces fail and pulses bus.timeout alongside it.
module pattern_checker
  import pattern_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4
`ifdef PATTERN_TIMEOUT_EN
  , parameter int TIMEOUT_TICKS = 2500
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic btnL,
  input  logic btnU,
  input  logic btnR,
  input  logic btnD,
  input  logic btnM,
  pattern_checker_if.slave bus
);

  localparam logic [2:0] SEQ_W = 3'(SEQ_LEN);

  logic [4:0] raw;
  logic [4:0] pulse;
  logic [3:0] dir_pulse;
  logic       m_pulse;
  logic       any_dir;
  logic       multi;
  logic [1:0] low_dir;
  logic [1:0] last_dir;

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [2:0] step_q, step_d;
  logic       pass_q, fail_q;
  logic       busy;

  // Bit index equals the direction code; bit 4 is the middle button
  assign raw = {btnM, btnD, btnR, btnU, btnL};

  for (genvar i = 0; i < 5; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db (
      .clk      (clk),
      .rst      (rst),
      .sample_en(sample_en),
      .btn_raw  (raw[i]),
      .press    (pulse[i])
    );
  end

  assign dir_pulse = pulse[3:0];
  assign m_pulse   = pulse[4];
  assign any_dir   = |dir_pulse;
  assign multi     = ($countones(pulse) > 1);
  assign busy      = (state_q == ENTRY) || (state_q == SUBMIT);

  // Lowest pressed direction code wins when several arrive together
  always_comb begin
    low_dir = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (dir_pulse[i]) low_dir = 2'(i);
    end
  end

  // press_dir must keep the last direction between presses
  always_ff @(posedge clk) begin
    if (rst) last_dir <= 2'd0;
    else if (any_dir) last_dir <= low_dir;
  end

`ifdef PATTERN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] timer_q;
  logic          to_d, to_q, timeout_q;
  logic          timer_hit;

  // Idle timer: runs on sample ticks only while armed, any press restarts it
  always_ff @(posedge clk) begin
    if (rst || !busy || (|pulse)) timer_q <= '0;
    else if (sample_en) timer_q <= timer_q + TW'(1);
  end

  assign timer_hit = busy && !(|pulse) && sample_en &&
                     (timer_q == TW'(TIMEOUT_TICKS - 1));
`endif

  // Next-state logic: start arms from IDLE, presses are scored in
  // ENTRY/SUBMIT, verdict states last one clock
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    step_d  = step_q;
`ifdef PATTERN_TIMEOUT_EN
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ENTRY;
          sel_d   = bus.random;
          step_d  = 3'd0;
        end
      end
      ENTRY: begin
        if (multi || m_pulse) begin
          state_d = FAIL;
        end else if (any_dir) begin
          if (low_dir == PATTERN_ROM[sel_q][step_q[1:0]]) begin
            step_d = step_q + 3'd1;
            if (step_q + 3'd1 == SEQ_W) state_d = SUBMIT;
          end else begin
            state_d = FAIL;
          end
        end
      end
      SUBMIT: begin
        if (multi || any_dir) state_d = FAIL;
        else if (m_pulse) state_d = PASS;
      end
      PASS:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef PATTERN_TIMEOUT_EN
    if (timer_hit) begin
      state_d = FAIL;
      to_d    = 1'b1;
    end
`endif
  end

  // State register plus verdict output registers (one clock behind state)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      step_q  <= 3'd0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      step_q  <= step_d;
      pass_q  <= (state_q == PASS);
      fail_q  <= (state_q == FAIL);
    end
  end

`ifdef PATTERN_TIMEOUT_EN
  // Remember that FAIL was entered by the timer so timeout lines up with fail
  always_ff @(posedge clk) begin
    if (rst) begin
      to_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      to_q      <= to_d;
      timeout_q <= (state_q == FAIL) && to_q;
    end
  end
  assign bus.timeout = timeout_q;
`endif

  assign bus.busy        = busy;
  assign bus.step        = step_q;
  assign bus.press_valid = any_dir;
  assign bus.press_dir   = any_dir ? low_dir : last_dir;
  assign bus.pass        = pass_q;
  assign bus.fail        = fail_q;

endmodule
